// File: rtl/weight_index_sequencer.sv
// Streams compressed weight-index chunks from the index buffer to the decoder,
// replaying one Kc group once per activation chunk, with a 1-entry skid buffer.
module weight_index_sequencer #(
  parameter int F     = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_nnz,
  input  logic [7:0]         cfg_num_act,
  input  logic               layer_change,
  input  logic               pe_stall,
  output logic               buf_rd_en,
  output logic [CNT_W-1:0]   buf_rd_addr,
  input  logic [F*IDX_W-1:0] buf_rd_data,
  output logic [F*IDX_W-1:0] dec_index,
  output logic [F-1:0]       dec_lane_valid,
  output logic               dec_next_a,
  output logic               dec_k_changing,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE, RUN, NEXT_A, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   nnz_q, chunks_q, rd_ptr, out_cnt, rd_addr_q;
  logic [7:0]         num_act_q, act_cnt;
  logic               rd_pend, k_chg_q;
  logic               out_valid, skid_valid;
  logic [F*IDX_W-1:0] out_data, skid_data, idx_masked;
  logic [CNT_W-1:0]   out_chunk, skid_chunk;
  logic [F-1:0]       lane_ok;
  logic [CNT_W:0]     nnz_round;
  logic               start, accept, last_accept;

  // Widen by one bit so the round-up add cannot wrap near the top of the range.
  assign nnz_round   = {1'b0, cfg_nnz} + (CNT_W+1)'(F - 1);
  assign start       = (state == IDLE) && cfg_valid;
  assign accept      = out_valid && !pe_stall;
  assign last_accept = accept && (state == RUN) && (out_cnt == chunks_q - CNT_W'(1));

  assign buf_rd_en   = (state == RUN) && !pe_stall && (rd_ptr < chunks_q) && !skid_valid;
  assign buf_rd_addr = rd_ptr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cfg_valid) state_nxt = (cfg_nnz == '0) ? DONE : RUN;
      RUN:    if (last_accept) state_nxt = (act_cnt < num_act_q - 8'd1) ? NEXT_A : DONE;
      NEXT_A: state_nxt = RUN;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (layer_change) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nnz_q <= '0; chunks_q <= '0; num_act_q <= '0;
      rd_ptr <= '0; out_cnt <= '0; act_cnt <= '0;
      rd_pend <= 1'b0; rd_addr_q <= '0; k_chg_q <= 1'b0;
      out_valid <= 1'b0; skid_valid <= 1'b0;
      out_data <= '0; skid_data <= '0; out_chunk <= '0; skid_chunk <= '0;
    end else if (layer_change) begin
      rd_pend <= 1'b0; k_chg_q <= 1'b0;
      out_valid <= 1'b0; skid_valid <= 1'b0;
    end else begin
      k_chg_q   <= start;
      rd_pend   <= buf_rd_en;
      rd_addr_q <= rd_ptr;
      if (start) begin
        nnz_q     <= cfg_nnz;
        chunks_q  <= CNT_W'(nnz_round / (CNT_W+1)'(F));
        num_act_q <= (cfg_num_act == 8'd0) ? 8'd1 : cfg_num_act;
        rd_ptr    <= '0;
        out_cnt   <= '0;
        act_cnt   <= '0;
      end else if (state == NEXT_A) begin
        rd_ptr  <= '0;
        out_cnt <= '0;
        if (act_cnt < num_act_q - 8'd1) act_cnt <= act_cnt + 8'd1;
      end else begin
        if (buf_rd_en) rd_ptr <= rd_ptr + CNT_W'(1);
        if (accept && (out_cnt < chunks_q - CNT_W'(1))) out_cnt <= out_cnt + CNT_W'(1);
      end
      // Skid drains ahead of new data so chunk order is preserved.
      if (accept || !out_valid) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_chunk  <= skid_chunk;
          out_valid  <= 1'b1;
          skid_valid <= rd_pend;
          if (rd_pend) begin
            skid_data  <= buf_rd_data;
            skid_chunk <= rd_addr_q;
          end
        end else if (rd_pend) begin
          out_data  <= buf_rd_data;
          out_chunk <= rd_addr_q;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_data  <= buf_rd_data;
        skid_chunk <= rd_addr_q;
        skid_valid <= 1'b1;
      end
    end
  end

  // Lane m of chunk c carries weight c*F+m; lanes past nnz are masked off.
  always_comb begin
    lane_ok    = '0;
    idx_masked = '0;
    for (int m = 0; m < F; m++) begin
      lane_ok[m] = (32'(out_chunk) * 32'(F) + 32'(m)) < 32'(nnz_q);
      idx_masked[m*IDX_W +: IDX_W] = lane_ok[m] ? out_data[m*IDX_W +: IDX_W] : '0;
    end
  end

  assign dec_index      = out_valid ? idx_masked : '0;
  assign dec_lane_valid = out_valid ? lane_ok : '0;
  assign dec_next_a     = (state == NEXT_A);
  assign dec_k_changing = k_chg_q;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_weight_index_sequencer.sv
// Bench for weight_index_sequencer: table of group configs, hand-timed corner
// sequences, and randomized groups checked against a chunk-stream model.
module tb_weight_index_sequencer;
  localparam int F = 4, IDX_W = 4, CNT_W = 10;
  localparam int DW = F * IDX_W, EW = F + DW;

  logic             clk, rst, cfg_valid, layer_change, pe_stall;
  logic [CNT_W-1:0] cfg_nnz, buf_rd_addr;
  logic [7:0]       cfg_num_act;
  logic             buf_rd_en, dec_next_a, dec_k_changing, busy, done;
  logic [DW-1:0]    buf_rd_data, dec_index;
  logic [F-1:0]     dec_lane_valid;
  logic [1:0]       dbg_state;

  weight_index_sequencer #(.F(F), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_nnz(cfg_nnz),
    .cfg_num_act(cfg_num_act), .layer_change(layer_change), .pe_stall(pe_stall),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .dec_index(dec_index), .dec_lane_valid(dec_lane_valid), .dec_next_a(dec_next_a),
    .dec_k_changing(dec_k_changing), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and buffer memory model (data valid one cycle after the read strobe)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) buf_rd_data <= buf_rd_en ? mem[buf_rd_addr] : DW'($urandom);

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] addr_q[$];
  int cnt_rd, cnt_next_a, cnt_done, cnt_kchg;
  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (buf_rd_en) begin
        cnt_rd++;
        check("rd_addr", 32'(buf_rd_addr), (addr_q.size() != 0) ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF);
      end
      if (pe_stall) check("rd_en_in_stall", 32'(buf_rd_en), 0);
      if (dec_lane_valid != '0 && !pe_stall)
        check("chunk", 32'({dec_lane_valid, dec_index}), (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF);
      if (dec_next_a) cnt_next_a++;
      if (done) cnt_done++;
      if (dec_k_changing) cnt_kchg++;
    end
  end

  // Reference: the group is num_act passes over ceil(nnz/F) chunks, weight c*F+m in lane m.
  task automatic push_model(input int nnz, input int num_act);
    int chunks = (nnz + F - 1) / F;
    int na = (num_act == 0) ? 1 : num_act;
    logic [DW-1:0] w, idx;
    logic [F-1:0] mask;
    for (int a = 0; a < na; a++)
      for (int c = 0; c < chunks; c++) begin
        w = mem[c]; idx = '0; mask = '0;
        for (int m = 0; m < F; m++)
          if (c * F + m < nnz) begin
            mask[m] = 1'b1;
            idx[m*IDX_W +: IDX_W] = w[m*IDX_W +: IDX_W];
          end
        addr_q.push_back(CNT_W'(c));
        exp_q.push_back({mask, idx});
      end
  endtask

  task automatic run_group(input int nnz, input int num_act, input int pct, input int st_start,
                           input int st_len, input int inj_k, input int exp_reads, input int exp_next_a);
    int k;
    exp_q.delete(); addr_q.delete();
    cnt_rd = 0; cnt_next_a = 0; cnt_done = 0; cnt_kchg = 0;
    push_model(nnz, num_act);
    mon_en = 1;
    @(posedge clk); #1;
    cfg_valid = 1; cfg_nnz = CNT_W'(nnz); cfg_num_act = 8'(num_act);
    @(posedge clk); #1;
    cfg_valid = 0;
    check("kchg_t1", 32'(dec_k_changing), 1);
    check("busy_t1", 32'(busy), 1);
    k = 1;
    while (busy && k < 3000) begin
      pe_stall  = (k >= st_start && k < st_start + st_len) || ($urandom_range(99) < pct);
      cfg_valid = (k == inj_k);
      cfg_nnz = 10'd3; cfg_num_act = 8'd7;
      @(posedge clk); #1;
      k++;
    end
    pe_stall = 0; cfg_valid = 0;
    check("timeout", 32'(k < 3000), 1);
    check("addr_left", addr_q.size(), 0);
    check("chunk_left", exp_q.size(), 0);
    check("reads", cnt_rd, exp_reads);
    check("next_a_cnt", cnt_next_a, exp_next_a);
    check("done_cnt", cnt_done, 1);
    check("kchg_cnt", cnt_kchg, 1);
    mon_en = 0;
  endtask

  typedef struct {
    int nnz, num_act, pct, st_start, st_len, inj_k, exp_reads, exp_next_a;
  } vec_t;
  vec_t vecs[9];

  initial begin
    logic [DW-1:0] w;
    int nnz, na, pct, na_eff, acc;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    vecs[0] = '{10, 1,  0, 0, 0, 0,  3, 0};
    vecs[1] = '{ 8, 3,  0, 0, 0, 0,  6, 2};
    vecs[2] = '{ 0, 1,  0, 0, 0, 0,  0, 0};
    vecs[3] = '{ 1, 0,  0, 0, 0, 0,  1, 0};
    vecs[4] = '{10, 1,  0, 2, 3, 0,  3, 0};
    vecs[5] = '{10, 1,  0, 3, 3, 0,  3, 0};
    vecs[6] = '{ 9, 2,  0, 0, 0, 4,  6, 1};
    vecs[7] = '{16, 4, 30, 0, 0, 0, 16, 3};
    vecs[8] = '{13, 1, 70, 0, 0, 0,  4, 0};

    // Reset, asserted together with cfg_valid and layer_change
    rst = 1; cfg_valid = 1; layer_change = 1; pe_stall = 0; cfg_nnz = 10'd5; cfg_num_act = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(buf_rd_en), 0);
    check("rst_index", 32'(dec_index), 0);
    check("rst_lanes", 32'(dec_lane_valid), 0);
    check("rst_next_a", 32'(dec_next_a), 0);
    check("rst_kchg", 32'(dec_k_changing), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 0; cfg_valid = 0; layer_change = 0;
    @(posedge clk); #1;

    // Single pass, exact cycle timing
    cfg_valid = 1; cfg_nnz = 10'd10; cfg_num_act = 8'd1;
    @(posedge clk); #1; cfg_valid = 0;
    check("sp_kchg", 32'(dec_k_changing), 1);
    check("sp_rd0", 32'({buf_rd_en, buf_rd_addr}), 32'h400);
    @(posedge clk); #1;
    check("sp_rd1", 32'({buf_rd_en, buf_rd_addr}), 32'h401);
    check("sp_kchg_off", 32'(dec_k_changing), 0);
    @(posedge clk); #1;
    check("sp_rd2", 32'({buf_rd_en, buf_rd_addr}), 32'h402);
    check("sp_c0", 32'({dec_lane_valid, dec_index}), 32'({4'hf, mem[0]}));
    @(posedge clk); #1;
    check("sp_rd_idle", 32'(buf_rd_en), 0);
    check("sp_c1", 32'({dec_lane_valid, dec_index}), 32'({4'hf, mem[1]}));
    @(posedge clk); #1;
    w = mem[2] & 16'h00ff;
    check("sp_c2", 32'({dec_lane_valid, dec_index}), 32'({4'h3, w}));
    @(posedge clk); #1;
    check("sp_done", 32'(done), 1);
    check("sp_empty", 32'(dec_lane_valid), 0);
    @(posedge clk); #1;
    check("sp_idle", 32'({busy, done}), 0);

    // Table of group configurations
    for (int i = 0; i < 9; i++)
      run_group(vecs[i].nnz, vecs[i].num_act, vecs[i].pct, vecs[i].st_start, vecs[i].st_len,
                vecs[i].inj_k, vecs[i].exp_reads, vecs[i].exp_next_a);

    // Abort during the second chunk, then layer_change overriding cfg_valid in IDLE
    cfg_valid = 1; cfg_nnz = 10'd12; cfg_num_act = 8'd2;
    @(posedge clk); #1; cfg_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("ab_c1", 32'({dec_lane_valid, dec_index}), 32'({4'hf, mem[1]}));
    layer_change = 1;
    @(posedge clk); #1; layer_change = 0;
    check("ab_busy", 32'(busy), 0);
    check("ab_out", 32'({dec_lane_valid, dec_index}), 0);
    check("ab_rd_en", 32'(buf_rd_en), 0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc += int'(done) + int'(dec_next_a) + int'(dec_k_changing) + int'(busy);
      @(posedge clk); #1;
    end
    check("ab_quiet", acc, 0);
    cfg_valid = 1; layer_change = 1; cfg_nnz = 10'd4;
    @(posedge clk); #1; cfg_valid = 0; layer_change = 0;
    check("ab_override", 32'({busy, dec_k_changing}), 0);
    run_group(4, 1, 0, 0, 0, 0, 1, 0);

    // Reset mid-run discards in-flight data
    cfg_valid = 1; cfg_nnz = 10'd12; cfg_num_act = 8'd1;
    @(posedge clk); #1; cfg_valid = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    check("mr_state", 32'({busy, buf_rd_en, dec_lane_valid}), 0);
    run_group(6, 1, 0, 0, 0, 0, 2, 0);

    // Randomized groups
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 16; j++) mem[j] = DW'($urandom);
      nnz = $urandom_range(0, 40);
      na  = $urandom_range(0, 4);
      pct = $urandom_range(0, 60);
      na_eff = (na == 0) ? 1 : na;
      run_group(nnz, na, pct, 0, 0, 0, ((nnz + F - 1) / F) * na_eff, (nnz == 0) ? 0 : na_eff - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
